// File: rtl/get_stream_fsm_if.sv
// Handshake bundle between the GET sub-FSM and its surroundings: the command
// side, the key-store lookup/verdict path, the beat stream and the status flags.
`timescale 1ns/1ps
interface get_stream_fsm_if #(
  parameter int KEY_W  = 32,
  parameter int VAL_W  = 64,
  parameter int BEAT_W = 32
);
  logic              en;
  logic              enter;
  logic [KEY_W-1:0]  key_i;
  logic              lookup_req_o;
  logic [KEY_W-1:0]  lookup_key_o;
  logic              hit_valid_i;
  logic              hit_i;
  logic [VAL_W-1:0]  rd_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [BEAT_W-1:0] out_data_o;
  logic              out_last_o;
  logic              done_o;
  logic              miss_o;
  logic              timeout_o;
  logic              busy_o;

  // The FSM side
  modport master (
    input  en, enter, key_i, hit_valid_i, hit_i, rd_data_i, out_ready_i,
    output lookup_req_o, lookup_key_o, out_valid_o, out_data_o, out_last_o,
           done_o, miss_o, timeout_o, busy_o
  );

  // The controller / key store / consumer side
  modport slave (
    output en, enter, key_i, hit_valid_i, hit_i, rd_data_i, out_ready_i,
    input  lookup_req_o, lookup_key_o, out_valid_o, out_data_o, out_last_o,
           done_o, miss_o, timeout_o, busy_o
  );
endinterface

// File: rtl/get_stream_fsm.sv
// GET sub-FSM of the cache controller. Latches the key on enter, fires a
// one-cycle lookup strobe, waits (bounded) for a hit/miss verdict and on a hit
// streams the value out LS beat first over valid/ready, finishing with a
// one-cycle done pulse plus miss/timeout status.
`timescale 1ns/1ps
module get_stream_fsm #(
  parameter int KEY_W   = 32,
  parameter int VAL_W   = 64,
  parameter int BEAT_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  get_stream_fsm_if.master bus
);

  localparam int BEATS   = (VAL_W + BEAT_W - 1) / BEAT_W;
  localparam int SHIFT_W = BEATS * BEAT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t             state;
  logic [KEY_W-1:0]   key_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [BEAT_CW-1:0] beat_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               lookup_req_q;
  logic               valid_q;
  logic               last_q;
  logic               done_q;
  logic               miss_q;
  logic               timeout_q;
  logic               busy_q;

  logic [BEAT_CW-1:0] beat_next;
  logic [CNT_W-1:0]   cnt_next;

  assign beat_next = beat_q + BEAT_CW'(1);
  assign cnt_next  = cnt_q + CNT_W'(1);

  // Valid is the only output that sees en directly: a frozen stream must
  // drop its valid in the same cycle so no beat can be taken while stalled.
  assign bus.lookup_req_o = lookup_req_q;
  assign bus.lookup_key_o = key_q;
  assign bus.out_valid_o  = valid_q & bus.en;
  assign bus.out_data_o   = shift_q[BEAT_W-1:0];
  assign bus.out_last_o   = last_q;
  assign bus.done_o       = done_q;
  assign bus.miss_o       = miss_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.busy_o       = busy_q;

  // State machine; each transition also sets the registered outputs for the state it enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      key_q        <= '0;
      shift_q      <= '0;
      beat_q       <= '0;
      cnt_q        <= '0;
      lookup_req_q <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      miss_q       <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else if (bus.en) begin
      if (bus.enter) begin
        // A new GET restarts from scratch and drops any in-flight one silently.
        state        <= ST_LOOKUP;
        key_q        <= bus.key_i;
        shift_q      <= '0;
        beat_q       <= '0;
        cnt_q        <= '0;
        lookup_req_q <= 1'b1;
        valid_q      <= 1'b0;
        last_q       <= 1'b0;
        done_q       <= 1'b0;
        miss_q       <= 1'b0;
        timeout_q    <= 1'b0;
        busy_q       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end

          ST_LOOKUP: begin
            state        <= ST_WAIT;
            lookup_req_q <= 1'b0;
            cnt_q        <= '0;
          end

          ST_WAIT: begin
            if (bus.hit_valid_i && bus.hit_i) begin
              state   <= ST_STREAM;
              shift_q <= SHIFT_W'(bus.rd_data_i);
              beat_q  <= '0;
              valid_q <= 1'b1;
              last_q  <= (BEATS == 1);
            end else if (bus.hit_valid_i) begin
              state  <= ST_DONE;
              miss_q <= 1'b1;
              done_q <= 1'b1;
            end else if (cnt_q == CNT_LIMIT) begin
              state     <= ST_DONE;
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_next;
            end
          end

          ST_STREAM: begin
            if (bus.out_ready_i) begin
              shift_q <= shift_q >> BEAT_W;
              if (beat_q == LAST_BEAT) begin
                state   <= ST_DONE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                beat_q <= beat_next;
                last_q <= (beat_next == LAST_BEAT);
              end
            end
          end

          ST_DONE: begin
            state     <= ST_IDLE;
            done_q    <= 1'b0;
            miss_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
          end

          default: begin
            state        <= ST_IDLE;
            lookup_req_q <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            miss_q       <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_get_stream_fsm.sv
// Directed bench for get_stream_fsm: instance A is 64-bit value / 32-bit beats
// with a short timeout, instance B is 40-bit value / 16-bit beats.
`timescale 1ns/1ps
module tb_get_stream_fsm;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  get_stream_fsm_if #(.KEY_W(32), .VAL_W(64), .BEAT_W(32)) bus_a ();
  get_stream_fsm_if #(.KEY_W(32), .VAL_W(40), .BEAT_W(16)) bus_b ();

  get_stream_fsm #(.KEY_W(32), .VAL_W(64), .BEAT_W(32), .TIMEOUT(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  get_stream_fsm #(.KEY_W(32), .VAL_W(40), .BEAT_W(16), .TIMEOUT(15)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit sel_b, input logic en, input logic enter,
                               input logic [31:0] key, input logic hv, input logic hit,
                               input logic [63:0] data, input logic ready);
    if (!sel_b) begin
      bus_a.en          = en;
      bus_a.enter       = enter;
      bus_a.key_i       = key;
      bus_a.hit_valid_i = hv;
      bus_a.hit_i       = hit;
      bus_a.rd_data_i   = data;
      bus_a.out_ready_i = ready;
    end else begin
      bus_b.en          = en;
      bus_b.enter       = enter;
      bus_b.key_i       = key;
      bus_b.hit_valid_i = hv;
      bus_b.hit_i       = hit;
      bus_b.rd_data_i   = data[39:0];
      bus_b.out_ready_i = ready;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_busy_a",    64'(bus_a.busy_o),       64'd0);
    checkOutput("rst_done_a",    64'(bus_a.done_o),       64'd0);
    checkOutput("rst_req_a",     64'(bus_a.lookup_req_o), 64'd0);
    checkOutput("rst_key_a",     64'(bus_a.lookup_key_o), 64'd0);
    checkOutput("rst_valid_a",   64'(bus_a.out_valid_o),  64'd0);
    checkOutput("rst_data_a",    64'(bus_a.out_data_o),   64'd0);
    checkOutput("rst_miss_a",    64'(bus_a.miss_o),       64'd0);
    checkOutput("rst_timeout_a", 64'(bus_a.timeout_o),    64'd0);
    checkOutput("rst_busy_b",    64'(bus_b.busy_o),       64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] T1 two-beat hit");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hCAFE, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("t1_req",      64'(bus_a.lookup_req_o), 64'd1);
    checkOutput("t1_key",      64'(bus_a.lookup_key_o), 64'hCAFE);
    checkOutput("t1_busy",     64'(bus_a.busy_o),       64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hCAFE, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("t1_req_drop", 64'(bus_a.lookup_req_o), 64'd0);
    checkOutput("t1_wait_val", 64'(bus_a.out_valid_o),  64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hCAFE, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hCAFE, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t1_b0_valid", 64'(bus_a.out_valid_o),  64'd1);
    checkOutput("t1_b0_data",  64'(bus_a.out_data_o),   64'h3333_4444);
    checkOutput("t1_b0_last",  64'(bus_a.out_last_o),   64'd0);
    tick();
    checkOutput("t1_b1_valid", 64'(bus_a.out_valid_o),  64'd1);
    checkOutput("t1_b1_data",  64'(bus_a.out_data_o),   64'h1111_2222);
    checkOutput("t1_b1_last",  64'(bus_a.out_last_o),   64'd1);
    checkOutput("t1_b1_done",  64'(bus_a.done_o),       64'd0);
    tick();
    checkOutput("t1_done",     64'(bus_a.done_o),       64'd1);
    checkOutput("t1_miss",     64'(bus_a.miss_o),       64'd0);
    checkOutput("t1_timeout",  64'(bus_a.timeout_o),    64'd0);
    checkOutput("t1_dn_valid", 64'(bus_a.out_valid_o),  64'd0);
    tick();
    checkOutput("t1_done_off", 64'(bus_a.done_o),       64'd0);
    checkOutput("t1_idle",     64'(bus_a.busy_o),       64'd0);

    $display("[TB] T2 miss");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h77, 1'b1, 1'b0, 64'hDEAD, 1'b1);
    checkOutput("t2_wait_val", 64'(bus_a.out_valid_o),  64'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t2_done",     64'(bus_a.done_o),       64'd1);
    checkOutput("t2_miss",     64'(bus_a.miss_o),       64'd1);
    checkOutput("t2_timeout",  64'(bus_a.timeout_o),    64'd0);
    checkOutput("t2_valid",    64'(bus_a.out_valid_o),  64'd0);
    tick();
    checkOutput("t2_miss_clr", 64'(bus_a.miss_o),       64'd0);
    checkOutput("t2_done_off", 64'(bus_a.done_o),       64'd0);

    $display("[TB] T3 timeout after four wait cycles");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("t3_w0_done",  64'(bus_a.done_o),       64'd0);
    tick();
    checkOutput("t3_w1_done",  64'(bus_a.done_o),       64'd0);
    tick();
    checkOutput("t3_w2_done",  64'(bus_a.done_o),       64'd0);
    tick();
    checkOutput("t3_w3_done",  64'(bus_a.done_o),       64'd0);
    checkOutput("t3_w3_busy",  64'(bus_a.busy_o),       64'd1);
    tick();
    checkOutput("t3_done",     64'(bus_a.done_o),       64'd1);
    checkOutput("t3_timeout",  64'(bus_a.timeout_o),    64'd1);
    checkOutput("t3_miss",     64'(bus_a.miss_o),       64'd0);
    tick();
    checkOutput("t3_to_clr",   64'(bus_a.timeout_o),    64'd0);

    $display("[TB] T4 backpressure and enable freeze");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t4_s0_valid", 64'(bus_a.out_valid_o),  64'd1);
    checkOutput("t4_s0_data",  64'(bus_a.out_data_o),   64'hCCCC_DDDD);
    tick();
    checkOutput("t4_s1_data",  64'(bus_a.out_data_o),   64'hCCCC_DDDD);
    tick();
    checkOutput("t4_s2_data",  64'(bus_a.out_data_o),   64'hCCCC_DDDD);
    checkOutput("t4_s2_last",  64'(bus_a.out_last_o),   64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_en0_val",  64'(bus_a.out_valid_o),  64'd0);
    checkOutput("t4_en0_data", 64'(bus_a.out_data_o),   64'hCCCC_DDDD);
    tick();
    checkOutput("t4_en1_val",  64'(bus_a.out_valid_o),  64'd0);
    checkOutput("t4_en1_busy", 64'(bus_a.busy_o),       64'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_rs_valid", 64'(bus_a.out_valid_o),  64'd1);
    checkOutput("t4_rs_data",  64'(bus_a.out_data_o),   64'hCCCC_DDDD);
    tick();
    checkOutput("t4_b1_data",  64'(bus_a.out_data_o),   64'hAAAA_BBBB);
    checkOutput("t4_b1_last",  64'(bus_a.out_last_o),   64'd1);
    tick();
    checkOutput("t4_done",     64'(bus_a.done_o),       64'd1);
    tick();

    $display("[TB] T5 three 16-bit beats from a 40-bit value");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h5, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t5_req",      64'(bus_b.lookup_req_o), 64'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h5, 1'b1, 1'b1, 64'hAB_CDEF_1234, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h5, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t5_b0_data",  64'(bus_b.out_data_o),   64'h1234);
    checkOutput("t5_b0_last",  64'(bus_b.out_last_o),   64'd0);
    tick();
    checkOutput("t5_b1_data",  64'(bus_b.out_data_o),   64'hCDEF);
    checkOutput("t5_b1_last",  64'(bus_b.out_last_o),   64'd0);
    tick();
    checkOutput("t5_b2_data",  64'(bus_b.out_data_o),   64'h00AB);
    checkOutput("t5_b2_last",  64'(bus_b.out_last_o),   64'd1);
    checkOutput("t5_b2_valid", 64'(bus_b.out_valid_o),  64'd1);
    tick();
    checkOutput("t5_done",     64'(bus_b.done_o),       64'd1);
    checkOutput("t5_a_idle",   64'(bus_a.busy_o),       64'd0);
    tick();

    $display("[TB] T6 re-enter during stream, then async reset in wait");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h9, 1'b1, 1'b1, 64'h0000_0002_0000_0001, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t6_b0_data",  64'(bus_a.out_data_o),   64'h1);
    tick();
    checkOutput("t6_b1_data",  64'(bus_a.out_data_o),   64'h2);
    checkOutput("t6_b1_last",  64'(bus_a.out_last_o),   64'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t6_req",      64'(bus_a.lookup_req_o), 64'd1);
    checkOutput("t6_key",      64'(bus_a.lookup_key_o), 64'h55);
    checkOutput("t6_no_done",  64'(bus_a.done_o),       64'd0);
    checkOutput("t6_valid",    64'(bus_a.out_valid_o),  64'd0);
    tick();
    checkOutput("t6_wait_dn",  64'(bus_a.done_o),       64'd0);
    checkOutput("t6_wait_busy",64'(bus_a.busy_o),       64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", 64'(bus_a.busy_o),       64'd0);
    checkOutput("t6_rst_done", 64'(bus_a.done_o),       64'd0);
    checkOutput("t6_rst_req",  64'(bus_a.lookup_req_o), 64'd0);
    checkOutput("t6_rst_key",  64'(bus_a.lookup_key_o), 64'd0);
    checkOutput("t6_rst_val",  64'(bus_a.out_valid_o),  64'd0);
    checkOutput("t6_rst_to",   64'(bus_a.timeout_o),    64'd0);
    checkOutput("t6_rst_miss", 64'(bus_a.miss_o),       64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("t6_post_busy", 64'(bus_a.busy_o),      64'd0);
    checkOutput("t6_post_done", 64'(bus_a.done_o),      64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
